// File: rtl/guess_round_if.sv
// guess_round_if: guess/scoring handshake between the edit FSM and the round controller
interface guess_round_if;
  logic        start;
  logic [24:0] guess;
  logic        guess_valid;
  logic        guess_ready;
  logic [24:0] target;
  logic [9:0]  colors;
  logic        result_valid;
  logic        guess_invalid;
  logic [2:0]  row_index;
  logic        busy;
  logic        win;
  logic        lose;
  modport master (
    output start, guess, guess_valid, target,
    input  guess_ready, colors, result_valid, guess_invalid, row_index, busy, win, lose
  );
  modport slave (
    input  start, guess, guess_valid, target,
    output guess_ready, colors, result_valid, guess_invalid, row_index, busy, win, lose
  );
endinterface

// File: rtl/guess_round_controller.sv
// guess_round_controller: sequences Wordle rounds and scores each guess one letter per cycle
module guess_round_controller #(
  parameter int MAX_ROWS   = 6,
  parameter int EMPTY_CODE = 26
) (
  input logic clk,
  input logic clr,
  guess_round_if.slave b
);
  typedef enum logic [2:0] {IDLE, WAIT_GUESS, GREEN, YELLOW, REPORT, DONE} state_t;
  state_t      state;
  logic [24:0] g_q, t_q;
  logic [2:0]  idx, hit_j, row_next;
  logic [4:0]  used, gl;
  logic        hit, bad, last, green_hit;
  // lowest unused target position holding the current guess letter
  always_comb begin
    gl = g_q[5*idx +: 5];
    hit = 1'b0;
    hit_j = '0;
    for (int j = 4; j >= 0; j--)
      if (!used[j] && t_q[5*j +: 5] == gl) begin
        hit = 1'b1;
        hit_j = 3'(j);
      end
    bad = 1'b0;
    for (int i = 0; i < 5; i++)
      bad = bad || b.guess[5*i +: 5] > 5'd25 || b.guess[5*i +: 5] == 5'(EMPTY_CODE);
  end
  assign green_hit     = gl == t_q[5*idx +: 5];
  assign last          = idx == 3'd4;
  assign row_next      = b.row_index + 3'd1;
  assign b.guess_ready  = state == WAIT_GUESS && !b.start;
  assign b.busy         = state == GREEN || state == YELLOW || state == REPORT;
  assign b.result_valid = state == REPORT;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      g_q <= '0;
      t_q <= '0;
      idx <= '0;
      used <= '0;
      b.colors <= '0;
      b.row_index <= '0;
      b.win <= 1'b0;
      b.lose <= 1'b0;
      b.guess_invalid <= 1'b0;
    end else begin
      b.guess_invalid <= 1'b0;
      if (b.start) begin
        state <= WAIT_GUESS;
        idx <= '0;
        used <= '0;
        b.colors <= '0;
        b.row_index <= '0;
        b.win <= 1'b0;
        b.lose <= 1'b0;
      end else
        case (state)
          WAIT_GUESS:
            if (b.guess_valid) begin
              if (bad) b.guess_invalid <= 1'b1;
              else begin
                g_q <= b.guess;
                t_q <= b.target;
                idx <= '0;
                used <= '0;
                b.colors <= '0;
                state <= GREEN;
              end
            end
          GREEN: begin
            if (green_hit) begin
              b.colors[2*idx +: 2] <= 2'b11;
              used[idx] <= 1'b1;
            end
            idx <= last ? 3'd0 : idx + 3'd1;
            state <= last ? YELLOW : GREEN;
          end
          YELLOW: begin
            if (b.colors[2*idx +: 2] != 2'b11) begin
              b.colors[2*idx +: 2] <= hit ? 2'b10 : 2'b01;
              if (hit) used[hit_j] <= 1'b1;
            end
            idx <= last ? 3'd0 : idx + 3'd1;
            state <= last ? REPORT : YELLOW;
          end
          REPORT:
            if (&b.colors) begin
              b.win <= 1'b1;
              state <= DONE;
            end else begin
              b.row_index <= row_next;
              b.lose <= row_next == 3'(MAX_ROWS);
              state <= row_next == 3'(MAX_ROWS) ? DONE : WAIT_GUESS;
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_guess_round_controller.sv
// tb_guess_round_controller: scoreboard bench for the round controller
module tb_guess_round_controller;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  guess_round_if b();
  guess_round_controller dut (.clk(clk), .clr(clr), .b(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [9:0] c;
    logic [2:0] r;
    logic       w;
    logic       l;
    int         acc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [24:0] pack(input int a, input int bb, input int c, input int d, input int f);
    return {5'(f), 5'(d), 5'(c), 5'(bb), 5'(a)};
  endfunction
  function automatic logic [9:0] score(input logic [24:0] g, input logic [24:0] t);
    logic [4:0] u = '0;
    logic [9:0] c = '0;
    logic       found;
    for (int i = 0; i < 5; i++)
      if (g[5*i +: 5] == t[5*i +: 5]) begin
        c[2*i +: 2] = 2'b11;
        u[i] = 1'b1;
      end
    for (int i = 0; i < 5; i++)
      if (c[2*i +: 2] != 2'b11) begin
        found = 1'b0;
        for (int j = 0; j < 5; j++)
          if (!found && !u[j] && t[5*j +: 5] == g[5*i +: 5]) begin
            found = 1'b1;
            u[j] = 1'b1;
          end
        c[2*i +: 2] = found ? 2'b10 : 2'b01;
      end
    return c;
  endfunction
  always @(negedge clk)
    if (b.result_valid) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = sb.pop_front();
        chk("colors", 32'(b.colors), 32'(e.c));
        chk("latency", 32'(cyc - e.acc + 1), 32'd11);
        @(posedge clk);
        #1;
        chk("row_index", 32'(b.row_index), 32'(e.r));
        chk("win", 32'(b.win), 32'(e.w));
        chk("lose", 32'(b.lose), 32'(e.l));
      end
    end
  task automatic do_start();
    b.start = 1'b1;
    @(posedge clk);
    #1 b.start = 1'b0;
    @(negedge clk);
  endtask
  task automatic submit(input logic [24:0] g, input logic [24:0] t, input logic push,
                        input logic [9:0] ec, input logic [2:0] er, input logic ew, input logic el);
    int n = 0;
    exp_t x;
    b.guess = g;
    b.target = t;
    while (!b.guess_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b.guess_ready) chk("ready_timeout", 0, 1);
    else begin
      b.guess_valid = 1'b1;
      @(posedge clk);
      #1;
      b.guess_valid = 1'b0;
      b.target = 25'h1ffffff;
      x.c = ec;
      x.r = er;
      x.w = ew;
      x.l = el;
      x.acc = cyc;
      if (push) sb.push_back(x);
      @(negedge clk);
    end
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    logic [24:0] t0, g;
    b.start = 1'b0;
    b.guess = '0;
    b.guess_valid = 1'b0;
    b.target = '0;
    t0 = pack(0, 1, 2, 3, 4);
    repeat (2) @(negedge clk);
    chk("rst_colors", 32'(b.colors), 0);
    chk("rst_row", 32'(b.row_index), 0);
    chk("rst_flags", {b.win, b.lose, b.result_valid, b.guess_invalid, b.busy, b.guess_ready}, 0);
    clr = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(b.guess_ready), 0);
    do_start();
    chk("start_ready", 32'(b.guess_ready), 1);
    submit(pack(4, 3, 2, 1, 0), t0, 1, 10'b1010111010, 3'd1, 0, 0);
    drain();
    submit(pack(1, 1, 1, 2, 2), pack(0, 1, 1, 3, 4), 1, 10'b0101111101, 3'd2, 0, 0);
    submit(pack(1, 1, 9, 9, 9), t0, 1, 10'b0101011101, 3'd3, 0, 0);
    drain();
    b.guess = pack(0, 1, 26, 3, 4);
    b.guess_valid = 1'b1;
    @(posedge clk);
    #1 b.guess_valid = 1'b0;
    chk("invalid_pulse", 32'(b.guess_invalid), 1);
    chk("invalid_row", 32'(b.row_index), 3);
    chk("invalid_ready", 32'(b.guess_ready), 1);
    @(negedge clk);
    chk("invalid_busy", 32'(b.busy), 0);
    @(posedge clk);
    #1 chk("invalid_one_cycle", 32'(b.guess_invalid), 0);
    @(negedge clk);
    submit(pack(4, 3, 2, 1, 0), t0, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
    chk("yellow_busy", 32'(b.busy), 1);
    do_start();
    chk("abort_row", 32'(b.row_index), 0);
    chk("abort_colors", 32'(b.colors), 0);
    chk("abort_ready", 32'(b.guess_ready), 1);
    repeat (15) @(negedge clk);
    b.guess = t0;
    b.guess_valid = 1'b1;
    do_start();
    b.guess_valid = 1'b0;
    chk("start_vs_valid_busy", 32'(b.busy), 0);
    chk("start_vs_valid_ready", 32'(b.guess_ready), 1);
    submit(t0, t0, 1, 10'h3ff, 3'd0, 1, 0);
    drain();
    b.guess_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("win_hold", {b.guess_ready, b.busy, b.win}, 3'b001);
    end
    b.guess_valid = 1'b0;
    do_start();
    chk("restart_win", 32'(b.win), 0);
    for (int k = 1; k <= 6; k++) begin
      g = pack($urandom_range(25, 1), $urandom_range(25, 0), $urandom_range(25, 0),
               $urandom_range(25, 0), $urandom_range(25, 0));
      submit(g, t0, 1, score(g, t0), 3'(k), 0, k == 6);
      drain();
    end
    b.guess = t0;
    b.guess_valid = 1'b1;
    repeat (20) @(negedge clk);
    b.guess_valid = 1'b0;
    chk("lose_ignore_busy", 32'(b.busy), 0);
    chk("lose_ignore_row", 32'(b.row_index), 6);
    chk("lose_sticky", {b.lose, b.guess_ready}, 2'b10);
    do_start();
    submit(pack(4, 3, 2, 1, 0), t0, 1, 10'b1010111010, 3'd1, 0, 0);
    drain();
    submit(pack(0, 1, 9, 9, 9), t0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr_colors", 32'(b.colors), 0);
    chk("clr_row", 32'(b.row_index), 0);
    chk("clr_flags", {b.win, b.lose, b.result_valid, b.guess_invalid, b.busy, b.guess_ready}, 0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    repeat (15) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/guess_round_controller.md
Name: guess_round_controller

Overview:
- Sequences one Wordle game round by round, and is the scoring datapath's controller.
- Accepts a submitted 5-letter guess from the edit FSM through a valid/ready handshake. Scores it against the target with the standard two-pass duplicate-aware rule (greens first, then yellows), one letter per cycle.
- Reports per-letter colours, tracks the attempt row, and flags win or lose for the top-level FSM and the VGA row renderer.

Parameters:
- MAX_ROWS, 6, number of guesses allowed before lose.
- EMPTY_CODE, 26, letter code that marks an unfilled cell. Any code above 25 is invalid.

Ports:
- clk  in  1  logic clock
- clr  in  1  asynchronous active-high reset
- start  in  1  pulse: begin a new game (aborts any game in progress)
- guess  in  25  letter i at [5i+4:5i], i=0..4; codes 0..25 = A..Z
- guess_valid  in  1  guess offered
- guess_ready  out  1  controller can accept a guess
- target  in  25  target word, same packing; sampled on guess acceptance
- colors  out  10  colour of letter i at [2i+1:2i]: 00 none, 01 grey, 10 yellow, 11 green
- result_valid  out  1  one-cycle pulse: colors is final for this row
- guess_invalid  out  1  one-cycle pulse: offered guess rejected
- row_index  out  3  current attempt row, 0..MAX_ROWS
- busy  out  1  scoring in progress
- win  out  1  sticky until start or clr
- lose  out  1  sticky until start or clr

Behaviour:
- Reset (clr high, asynchronous), all outputs 0:
  - state IDLE; colors=0, row_index=0, win=0, lose=0, result_valid=0, guess_invalid=0, busy=0, guess_ready=0.
- States: IDLE, WAIT_GUESS, GREEN, YELLOW, REPORT, DONE.
- start has priority over everything except clr. In any state it:
  - clears colors, row_index, win and lose;
  - clears the internal used-position mask;
  - moves to WAIT_GUESS on the next edge.
- guess_ready = (state==WAIT_GUESS) && !start. A guess is accepted on an edge where guess_valid && guess_ready.
- Accept edge:
  - If any letter is above 25, assert guess_invalid for one cycle, stay in WAIT_GUESS, and leave row_index unchanged.
  - Otherwise latch guess and target, clear colors and the used mask, and go to GREEN with index i=0.
- GREEN: 5 cycles, i=0..4.
  - If guess[i]==target[i], set colors[i]=green and used[i]=1.
  - Otherwise leave colors[i] at 00.
- YELLOW: 5 cycles, i=0..4.
  - Skip letters already green.
  - Otherwise find the lowest j with !used[j] && target[j]==guess[i]. If found, set colors[i]=yellow and used[j]=1; else set colors[i]=grey.
- REPORT: 1 cycle, result_valid=1.
  - All 5 letters green: win=1, go to DONE.
  - Else row_index+1. If the new value equals MAX_ROWS: lose=1, go to DONE. Otherwise go to WAIT_GUESS.
- Latency: accept at edge N. GREEN occupies cycles N+1..N+5, YELLOW N+6..N+10, result_valid is high in cycle N+11, and the next guess_ready is in cycle N+12 (if not won or lost).
- busy=1 in GREEN, YELLOW and REPORT.
- colors holds its value until the next accepted guess, start, or clr.
- DONE: guess_ready=0; guess_valid is ignored. Leaves only on start.
- start during GREEN or YELLOW abandons the row: no result_valid, and row_index is cleared.
- guess_valid held high across REPORT is not accepted until WAIT_GUESS; it is never double-accepted.
- The target is not re-read during scoring; changes to the target port mid-row do not affect the result.

Test Plan:
- Yellow and green mix: reset, start, target={0,1,2,3,4}, guess={4,3,2,1,0} -> result_valid exactly 11 cycles after accept, colors=10'b1010111010, row_index=1, win=0.
- Duplicates consumed by greens: target={0,1,1,3,4}, guess={1,1,1,2,2} -> colors=10'b0101111101. Also target={0,1,2,3,4}, guess={1,1,9,9,9} -> colors=10'b0101011101.
- Win: guess equals target -> colors=10'h3FF, win=1 on the cycle after result_valid, guess_ready stays 0 until start.
- Lose: six non-matching valid guesses -> row_index=6, lose=1 after the 6th result_valid; a 7th guess_valid is ignored.
- Invalid guess: a letter equal to EMPTY_CODE (26) -> guess_invalid 1-cycle pulse, row_index unchanged, guess_ready stays 1.
- Aborts:
  - start asserted during YELLOW -> no result_valid, row_index=0, colors=0, WAIT_GUESS next.
  - start and guess_valid in the same cycle -> guess not accepted.
  - clr mid-GREEN -> all outputs 0 immediately.
